// File: rtl/fmul_pkg.sv
// fmul_pkg: shared single-precision field layout and helpers for the fmul scheduler slice
package fmul_pkg;
    localparam int FP32_W   = 32;
    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
    localparam int EXP_BIAS = 127;
    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp32_t;
    function automatic logic fp32_is_zero_exp(input fp32_t x);
        return x.exp == '0;
    endfunction
endpackage

// File: rtl/floatingmultiplication.sv
// floatingmultiplication: combinational fp32 multiply, truncating mantissa, no rounding or special cases
module floatingmultiplication
    import fmul_pkg::*;
(
    input  logic [FP32_W-1:0] a,
    input  logic [FP32_W-1:0] b,
    output logic [FP32_W-1:0] result
);
    fp32_t fa, fb, fr;
    logic [MAN_W:0] ma, mb;
    logic [MAN_W+1:0] hi;
    assign fa = a;
    assign fb = b;
    assign ma = {1'b1, fa.man};
    assign mb = {1'b1, fb.man};
    // only product bits [47:23] matter once the mantissa is truncated
    assign hi = (MAN_W+2)'((48'(ma) * 48'(mb)) >> MAN_W);
    always_comb begin
        fr.sign = fa.sign ^ fb.sign;
        fr.exp  = fa.exp + fb.exp - EXP_W'(EXP_BIAS) + {{(EXP_W-1){1'b0}}, hi[MAN_W+1]};
        fr.man  = hi[MAN_W+1] ? hi[MAN_W:1] : hi[MAN_W-1:0];
    end
    assign result = fr;
endmodule

// File: rtl/fmul_rr_pick.sv
// fmul_rr_pick: combinational round-robin pick, first set request at or after ptr with wrap
module fmul_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx,
    output logic               any
);
    logic found;
    assign any = |req;
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req[(int'(ptr) + k) % NUM_REQ]) begin
                grant[(int'(ptr) + k) % NUM_REQ] = 1'b1;
                idx   = ID_W'((int'(ptr) + k) % NUM_REQ);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/fmul_rr_scheduler.sv
// fmul_rr_scheduler: round-robin sharing of one fp32 multiplier with a one-entry tagged response buffer
// Define FMUL_SCHED_FLUSH_EN to force a signed zero when either operand has a zero exponent field.
module fmul_rr_scheduler
    import fmul_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [FP32_W*NUM_REQ-1:0] req_a,
    input  logic [FP32_W*NUM_REQ-1:0] req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [FP32_W-1:0]         rsp_result,
    output logic [ID_W-1:0]           rsp_id,
    output logic [CNT_W-1:0]          op_count
);
    logic [ID_W-1:0]    rr_ptr, idx;
    logic [NUM_REQ-1:0] grant;
    logic               any, can_issue, fire;
    fp32_t              op_a, op_b, prod, next_result;
    fmul_rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (idx),
        .any   (any)
    );
    assign can_issue = !rsp_valid || rsp_ready;
    assign req_ready = can_issue ? grant : '0;
    assign fire      = can_issue && any;
    assign op_a      = req_a[int'(idx)*FP32_W +: FP32_W];
    assign op_b      = req_b[int'(idx)*FP32_W +: FP32_W];
    floatingmultiplication u_mul (
        .a      (op_a),
        .b      (op_b),
        .result (prod)
    );
`ifdef FMUL_SCHED_FLUSH_EN
    assign next_result = (fp32_is_zero_exp(op_a) || fp32_is_zero_exp(op_b)) ? {prod.sign, 31'b0} : prod;
`else
    assign next_result = prod;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_id     <= '0;
            rr_ptr     <= '0;
            op_count   <= '0;
        end else begin
            if (fire) begin
                rsp_valid  <= 1'b1;
                rsp_result <= next_result;
                rsp_id     <= idx;
                rr_ptr     <= (int'(idx) == NUM_REQ - 1) ? '0 : idx + 1'b1;
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
            if (rsp_valid && rsp_ready)
                op_count <= op_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_fmul_rr_scheduler.sv
// tb_fmul_rr_scheduler: directed checks of grant order, buffering, backpressure, reset and counter wrap
module tb_fmul_rr_scheduler;
    logic         clk = 0;
    logic         rst = 1;
    logic [3:0]   req_valid = '0;
    logic [3:0]   req_ready;
    logic [127:0] req_a = '0;
    logic [127:0] req_b = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b1;
    logic [31:0]  rsp_result;
    logic [1:0]   rsp_id;
    logic [3:0]   op_count;
    int           n_chk = 0;
    int           n_fail = 0;

    fmul_rr_scheduler #(.NUM_REQ(4), .ID_W(2), .CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_id     (rsp_id),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        req_a[31:0]   = 32'h40000000; req_b[31:0]   = 32'h40400000;
        req_a[63:32]  = 32'hC0000000; req_b[63:32]  = 32'h40800000;
        req_a[95:64]  = 32'h3FC00000; req_b[95:64]  = 32'h3FC00000;
        req_a[127:96] = 32'h3F800000; req_b[127:96] = 32'h40000000;
        step();
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_result", rsp_result, 32'd0);
        chk("rst_id", 32'(rsp_id), 32'd0);
        chk("rst_count", 32'(op_count), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        rst = 0;
        step();
        // single request from requester 0: 2.0 * 3.0
        req_valid = 4'b0001; #1;
        chk("single_ready", 32'(req_ready), 32'h1);
        step(); req_valid = '0;
        chk("single_valid", 32'(rsp_valid), 32'd1);
        chk("single_result", rsp_result, 32'h40C00000);
        chk("single_id", 32'(rsp_id), 32'd0);
        step();
        chk("single_count", 32'(op_count), 32'd1);
        chk("single_drained", 32'(rsp_valid), 32'd0);
        // sign: -2.0 * 4.0 from requester 1
        req_valid = 4'b0010; #1;
        chk("sign_ready", 32'(req_ready), 32'h2);
        step(); req_valid = '0;
        chk("sign_result", rsp_result, 32'hC1000000);
        chk("sign_id", 32'(rsp_id), 32'd1);
        step();
        chk("sign_count", 32'(op_count), 32'd2);
        // backpressure: 1.5*1.5 from requester 2 held while requester 3 waits
        rsp_ready = 1'b0; req_valid = 4'b0100; #1;
        chk("bp_ready", 32'(req_ready), 32'h4);
        step(); req_valid = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_result", rsp_result, 32'h40100000);
            chk("bp_id", 32'(rsp_id), 32'd2);
            chk("bp_ready_low", 32'(req_ready), 32'd0);
            step();
        end
        rsp_ready = 1'b1; #1;
        chk("bp_release_ready", 32'(req_ready), 32'h8);
        step(); req_valid = '0;
        chk("bp_next_result", rsp_result, 32'h40000000);
        chk("bp_next_id", 32'(rsp_id), 32'd3);
        chk("bp_count", 32'(op_count), 32'd3);
        step();
        chk("bp_count2", 32'(op_count), 32'd4);
        // fairness: all requesters held, pointer now at 0
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("fair_ready", 32'(req_ready), 32'(4'b0001 << (k % 4)));
            step();
            chk("fair_id", 32'(rsp_id), 32'(k % 4));
            chk("fair_valid", 32'(rsp_valid), 32'd1);
        end
        req_valid = '0;
        step();
        chk("fair_count", 32'(op_count), 32'd9);
        chk("fair_drained", 32'(rsp_valid), 32'd0);
        // reset with a buffered result
        req_valid = 4'b0010;
        step(); req_valid = '0;
        chk("mid_valid", 32'(rsp_valid), 32'd1);
        #2 rst = 1; #1;
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_count", 32'(op_count), 32'd0);
        chk("mid_rst_result", rsp_result, 32'd0);
        req_valid = 4'b1111; #1;
        chk("mid_rst_ptr", 32'(req_ready), 32'h1);
        step();
        rst = 0; req_valid = 4'b1000; #1;
        chk("post_rst_ready", 32'(req_ready), 32'h8);
        step(); req_valid = '0;
        chk("post_rst_id", 32'(rsp_id), 32'd3);
        chk("post_rst_result", rsp_result, 32'h40000000);
        step();
        chk("post_rst_count", 32'(op_count), 32'd1);
        // 16 more responses: 17 total wraps the 4-bit counter to 1
        req_valid = 4'b0001;
        for (int i = 0; i < 16; i++) step();
        chk("wrap_pre", 32'(op_count), 32'd0);
        req_valid = '0;
        step();
        chk("wrap_count", 32'(op_count), 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
